// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial-pattern detector.
//   state_t      controller state encoding (IDLE / RUN / DONE)
//   SEQ_MAX_LEN  default maximum pattern length in bits
//   SEQ_LEN_W    width of a length field for the default SEQ_MAX_LEN
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_LEN_W   = $clog2(SEQ_MAX_LEN + 1);

endpackage

// File: rtl/seq_match_core.sv
// Pattern-match engine: history shift register, saturating bits_seen counter
// and a length-masked comparator.
//   clk, rst   clock and synchronous active-high reset
//   clear      restart: empties history and bits_seen
//   shift_en   accept x as a new sample this cycle
//   x          serial data bit
//   pattern    reference pattern, bit[len-1] is the oldest expected bit
//   len        active pattern length (already clamped to 1..MAX_LEN)
//   overlap    1 = matches may share samples
//   match      combinational: the sample being accepted completes a match
module seq_match_core
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    // Only MAX_LEN-1 past samples need storing: the comparison always looks
    // at the history as it will be after the current sample is shifted in.
    logic [MAX_LEN-2:0] hist_r;
    logic [MAX_LEN-1:0] hist_nxt_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W-1:0]   seen_r;
    logic [LEN_W-1:0]   seen_nxt_s;

    assign hist_nxt_s = {hist_r, x};

    // Build the mask selecting the low len bits of history and pattern.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // Sample count after this shift, saturating at len.
    always_comb begin
        seen_nxt_s = seen_r;
        if (seen_r >= len) begin
            seen_nxt_s = len;
        end else begin
            seen_nxt_s = seen_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end
    end

    assign match = shift_en && (seen_nxt_s >= len) &&
                   ((hist_nxt_s & mask_s) == (pattern & mask_s));

    // History and bits_seen registers; a non-overlapping match restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= {(MAX_LEN-1){1'b0}};
            seen_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            hist_r <= {(MAX_LEN-1){1'b0}};
            seen_r <= {LEN_W{1'b0}};
        end else if (shift_en) begin
            hist_r <= hist_nxt_s[MAX_LEN-2:0];
            if (match && !overlap) begin
                seen_r <= {LEN_W{1'b0}};
            end else begin
                seen_r <= seen_nxt_s;
            end
        end else begin
            hist_r <= hist_r;
            seen_r <= seen_r;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector controller. Latches pattern/length/
// overlap configuration while idle, arms the match engine on start, and
// pulses z one cycle after each sample that completes a match.
// Optional feature macro: MATCH_COUNT_EN (match counter with auto-done).
//   clk, rst              clock and synchronous active-high reset
//   cfg_valid/cfg_ready   configuration handshake (ready only in IDLE)
//   cfg_pattern, cfg_len, cfg_overlap, cfg_target   configuration fields
//   start, stop           arm from IDLE / abort a run
//   x, x_valid            qualified serial input
//   z                     one-cycle match pulse
//   busy                  high while running
//   done                  one-cycle pulse when the match target is reached
//   match_count           matches in the current run
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = 8
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         x,
    input  logic                         x_valid,
    output logic                         z,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             match_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE_V = LEN_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [CNT_W-1:0]   target_r;
    logic               cfg_fire_s;
    logic               arm_s;
    logic               shift_en_s;
    logic               match_s;
    logic               done_hit_s;
    logic               z_r;
    logic               busy_r;
    logic               done_r;
    logic               cfg_ready_r;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (l == {LEN_W{1'b0}}) begin
            r = LEN_ONE_V;
        end else if (l > LEN_MAX_V) begin
            r = LEN_MAX_V;
        end else begin
            r = l;
        end
        return r;
    endfunction

    assign cfg_fire_s = cfg_valid && cfg_ready_r;
    assign arm_s      = (state_r == IDLE) && start;
    // stop takes priority: a sample arriving with stop is dropped.
    assign shift_en_s = (state_r == RUN) && x_valid && !stop;

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (arm_s),
        .shift_en (shift_en_s),
        .x        (x),
        .pattern  (pattern_r),
        .len      (len_r),
        .overlap  (overlap_r),
        .match    (match_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                end else if (done_hit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Configuration registers; a start in the same cycle runs with the new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= {MAX_LEN{1'b0}};
            len_r     <= LEN_ONE_V;
            overlap_r <= 1'b1;
            target_r  <= {CNT_W{1'b0}};
        end else if (cfg_fire_s) begin
            pattern_r <= cfg_pattern;
            len_r     <= clamp_len(cfg_len);
            overlap_r <= cfg_overlap;
            target_r  <= cfg_target;
        end else begin
            pattern_r <= pattern_r;
            len_r     <= len_r;
            overlap_r <= overlap_r;
            target_r  <= target_r;
        end
    end

    // Registered status and pulse outputs, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r         <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            z_r         <= match_s;
            done_r      <= done_hit_s;
            busy_r      <= (state_nxt_s == RUN);
            cfg_ready_r <= (state_nxt_s == IDLE);
        end
    end

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_inc_s;

    // Saturating increment of the match counter.
    always_comb begin
        count_inc_s = count_r;
        if (count_r == {CNT_W{1'b1}}) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign done_hit_s = match_s && (target_r != {CNT_W{1'b0}}) &&
                        (count_inc_s == target_r);

    // Match counter, cleared when a run is armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (arm_s) begin
            count_r <= {CNT_W{1'b0}};
        end else if (match_s) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign match_count = count_r;
`else
    logic unused_target_s;

    assign done_hit_s      = 1'b0;
    assign match_count     = {CNT_W{1'b0}};
    assign unused_target_s = ^target_r;
`endif

    assign z         = z_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios followed by
// randomized traffic, all checked every cycle against a sample-queue model.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef MATCH_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               x;
    logic               x_valid;
    logic               z;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   match_count;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 finishing after target.
    int               m_phase;
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_tgt;
    int               m_cnt;
    bit               m_hist[$];
    logic             exp_z;
    logic             exp_done;
    int               zseen;
    int               doneseen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Apply one clock edge with the current inputs, advance the model, compare.
    task automatic tick();
        bit hit;
        int v;
        exp_z    = 1'b0;
        exp_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_pat = '0; m_len = 1; m_ovl = 1'b1; m_tgt = 0; m_cnt = 0;
            m_hist.delete();
        end else if (m_phase == 0) begin
            if (cfg_valid) begin
                m_pat = cfg_pattern;
                m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
                m_ovl = cfg_overlap;
                m_tgt = int'(cfg_target);
            end
            if (start) begin
                m_phase = 1; m_cnt = 0;
                m_hist.delete();
            end
        end else if (m_phase == 1) begin
            if (stop) begin
                m_phase = 0;
            end else if (x_valid) begin
                m_hist.push_back(x);
                if (m_hist.size() > m_len) void'(m_hist.pop_front());
                hit = 1'b0;
                if (m_hist.size() == m_len) begin
                    v = 0;
                    foreach (m_hist[i]) v = (v << 1) | int'(m_hist[i]);
                    hit = (v == (int'(m_pat) & ((1 << m_len) - 1)));
                end
                if (hit) begin
                    exp_z = 1'b1;
                    if (!m_ovl) m_hist.delete();
                    if (COUNT_EN) begin
                        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                        if (m_tgt != 0 && m_cnt == m_tgt) begin
                            exp_done = 1'b1;
                            m_phase  = 2;
                        end
                    end
                end
            end
        end else begin
            m_phase = 0;
        end
        @(posedge clk);
        #1;
        chk("z", 32'(z), 32'(exp_z));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_phase == 0));
        chk("match_count", 32'(match_count), 32'(m_cnt));
        if (z === 1'b1) zseen++;
        if (done === 1'b1) doneseen++;
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input bit ov, input logic [CNT_W-1:0] t, input bit with_start);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
        start = with_start;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic feed(input bit b);
        x = b; x_valid = 1'b1; tick(); x_valid = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        bit s1[12];
        bit s2[7];
        int ones;
        bit b;
        s1 = '{0,0,1,1,0,1,1,0,0,1,1,0};
        s2 = '{1,0,1,1,0,1,1};
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
        zseen = 0; doneseen = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: overlapping 0110 -> three matches
        configure(8'h06, 4'd4, 1'b1, 8'd0, 1'b0);
        arm();
        zseen = 0;
        foreach (s1[i]) feed(s1[i]);
        tick();
        chk("t1_zcount", 32'(zseen), 32'd3);
        halt();

        // 2: 1011 with and without overlap
        configure(8'h0B, 4'd4, 1'b1, 8'd0, 1'b1);
        zseen = 0;
        foreach (s2[i]) feed(s2[i]);
        tick();
        chk("t2_ovl_zcount", 32'(zseen), 32'd2);
        halt();
        configure(8'h0B, 4'd4, 1'b0, 8'd0, 1'b1);
        zseen = 0;
        foreach (s2[i]) feed(s2[i]);
        tick();
        chk("t2_noovl_zcount", 32'(zseen), 32'd1);
        halt();

        // 3: counted run finishing at the second match
        if (COUNT_EN) begin
            configure(8'h06, 4'd4, 1'b1, 8'd2, 1'b1);
            zseen = 0; doneseen = 0;
            foreach (s1[i]) feed(s1[i]);
            tick();
            chk("t3_zcount", 32'(zseen), 32'd2);
            chk("t3_donecount", 32'(doneseen), 32'd1);
            chk("t3_count", 32'(match_count), 32'd2);
            chk("t3_idle", 32'(cfg_ready), 32'd1);
        end

        // 4: stop on the completing sample suppresses the match
        configure(8'h06, 4'd4, 1'b1, 8'd0, 1'b1);
        zseen = 0;
        feed(1'b0); feed(1'b1); feed(1'b1);
        x = 1'b0; x_valid = 1'b1; stop = 1'b1;
        tick();
        x_valid = 1'b0; stop = 1'b0;
        tick();
        chk("t4_zcount", 32'(zseen), 32'd0);
        chk("t4_ready", 32'(cfg_ready), 32'd1);

        // 5: config ignored while running; length 0 clamps to 1
        arm();
        configure(8'h09, 4'd4, 1'b0, 8'd0, 1'b0);
        zseen = 0;
        feed(1'b0); feed(1'b1); feed(1'b1); feed(1'b0);
        tick();
        chk("t5_oldpat", 32'(zseen), 32'd1);
        halt();
        configure(8'h01, 4'd0, 1'b0, 8'd0, 1'b1);
        zseen = 0; ones = 0;
        for (int i = 0; i < 10; i++) begin
            b = 1'(i % 3 != 1);
            if (b) ones++;
            feed(b);
        end
        tick();
        chk("t5_len1", 32'(zseen), 32'(ones));
        halt();

        // 6: reset mid-run, then a fresh run needs four new bits
        configure(8'h06, 4'd4, 1'b1, 8'd0, 1'b1);
        feed(1'b0); feed(1'b1); feed(1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        configure(8'h06, 4'd4, 1'b1, 8'd0, 1'b1);
        zseen = 0;
        feed(1'b0);
        tick();
        chk("t6_partial", 32'(zseen), 32'd0);
        feed(1'b0); feed(1'b1); feed(1'b1); feed(1'b0);
        tick();
        chk("t6_full", 32'(zseen), 32'd1);
        halt();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(249) == 0);
            cfg_valid   = ($urandom_range(19) == 0);
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 3));
            start       = ($urandom_range(7) == 0);
            stop        = ($urandom_range(59) == 0);
            x_valid     = ($urandom_range(9) < 7);
            x           = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
